// File: rtl/multich_variable_delay_if.sv
// multich_variable_delay_if
//   Groups the data and status signals of the multi-channel variable delay line.
//   The design's own clock and reset are plain ports and are not part of this interface.
//
//   Signals:
//     DIN         packed input samples, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//     DELAY       packed per-channel delay requests, channel c at [c*DW_D +: DW_D]
//     DOUT        packed delayed samples, laid out the same way as DIN
//     DOUT_VALID  per-channel flag: the delay history is complete
//     DELAY_ERR   per-channel sticky flag: a delay request exceeded MAX_DELAY_LENGTH
//
//   Modports:
//     master  the stimulus or upstream side; drives DIN and DELAY
//     slave   the delay line; drives DOUT, DOUT_VALID and DELAY_ERR
interface multich_variable_delay_if #(
    parameter int DATA_WIDTH       = 16,
    parameter int CH_NUM           = 4,
    parameter int MAX_DELAY_LENGTH = 64
);
    localparam int DW_D = $clog2(MAX_DELAY_LENGTH + 1);

    logic [CH_NUM*DATA_WIDTH-1:0] DIN;
    logic [CH_NUM*DW_D-1:0]       DELAY;
    logic [CH_NUM*DATA_WIDTH-1:0] DOUT;
    logic [CH_NUM-1:0]            DOUT_VALID;
    logic [CH_NUM-1:0]            DELAY_ERR;

    modport master (output DIN, output DELAY, input DOUT, input DOUT_VALID, input DELAY_ERR);
    modport slave  (input DIN, input DELAY, output DOUT, output DOUT_VALID, output DELAY_ERR);
endinterface

// File: rtl/multich_variable_delay.sv
// multich_variable_delay
//   Multi-channel delay line with a run-time delay for each channel.
//   Each channel delays its own sample stream by 0..MAX_DELAY_LENGTH cycles.
//   All channels share one circular buffer and one write pointer.
//   A channel's output stays at zero and its valid flag stays low until the
//   buffer holds a full history at the current delay. This applies after reset
//   and after every change of the effective delay.
//
//   Ports:
//     CLK  system clock, rising edge
//     RST  asynchronous, active-high reset
//     bus  multich_variable_delay_if.slave (DIN, DELAY in; DOUT, DOUT_VALID, DELAY_ERR out)
//
//   Optional build macro:
//     OUTPUT_REG_EN  adds one register stage on DOUT and DOUT_VALID, which adds
//                    one cycle to every output latency, including the zero-delay
//                    bypass. DELAY_ERR timing is not affected.
module multich_variable_delay #(
    parameter int DATA_WIDTH       = 16,
    parameter int CH_NUM           = 4,
    parameter int MAX_DELAY_LENGTH = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    multich_variable_delay_if.slave bus
);
    localparam int              DW_D  = $clog2(MAX_DELAY_LENGTH + 1);
    localparam int              AW    = $clog2(MAX_DELAY_LENGTH);
    localparam logic [DW_D-1:0] MAX_D = DW_D'(MAX_DELAY_LENGTH);

    logic [CH_NUM*DATA_WIDTH-1:0] mem [MAX_DELAY_LENGTH];
    logic [AW-1:0]                wptr;

    // The buffer is not reset; the fill tracking keeps stale slots hidden.
    always_ff @(posedge CLK) begin
        mem[wptr] <= bus.DIN;
    end

    // wptr wraps naturally because the depth is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
        end else begin
            wptr <= wptr + AW'(1);
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [DW_D-1:0]       req;
        logic [DW_D-1:0]       d_eff;
        logic [DW_D-1:0]       dly_prev;
        logic [DW_D-1:0]       fill_cnt;
        logic                  err_q;
        logic [AW-1:0]         rd_addr;
        logic [DATA_WIDTH-1:0] rd_data;
        logic [DATA_WIDTH-1:0] dout_c;
        logic                  valid_c;

        assign req   = bus.DELAY[c*DW_D +: DW_D];
        assign d_eff = (req > MAX_D) ? MAX_D : req;

        // The read happens before this edge's write. When d_eff equals the
        // depth, its low AW bits are zero, so the read address is wptr itself:
        // the slot that is about to be overwritten, holding the oldest sample.
        assign rd_addr = wptr - d_eff[AW-1:0];
        assign rd_data = mem[rd_addr][c*DATA_WIDTH +: DATA_WIDTH];

        // A change of d_eff restarts the fill count. The reset value of
        // dly_prev is zero, so after reset every non-zero delay looks like a
        // change, which costs one extra edge before the output becomes valid.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                fill_cnt <= '0;
                dly_prev <= '0;
                err_q    <= 1'b0;
            end else begin
                dly_prev <= d_eff;
                if (d_eff != dly_prev) begin
                    fill_cnt <= '0;
                end else if (fill_cnt != MAX_D) begin
                    fill_cnt <= fill_cnt + DW_D'(1);
                end
                if (req > MAX_D) begin
                    err_q <= 1'b1;
                end
            end
        end

        assign valid_c = !RST && (fill_cnt >= d_eff);
        assign dout_c  = !valid_c         ? '0 :
                         (d_eff == '0)    ? bus.DIN[c*DATA_WIDTH +: DATA_WIDTH] :
                                            rd_data;

        assign bus.DELAY_ERR[c] = err_q;

`ifdef OUTPUT_REG_EN
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  valid_q;

        // One extra stage so the outputs are driven straight from flops.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                dout_q  <= dout_c;
                valid_q <= valid_c;
            end
        end

        assign bus.DOUT[c*DATA_WIDTH +: DATA_WIDTH] = dout_q;
        assign bus.DOUT_VALID[c]                    = valid_q;
`else
        assign bus.DOUT[c*DATA_WIDTH +: DATA_WIDTH] = dout_c;
        assign bus.DOUT_VALID[c]                    = valid_c;
`endif
    end
endmodule

// File: tb/tb_multich_variable_delay.sv
// tb_multich_variable_delay
//   Self-checking bench for multich_variable_delay.
//   A reference model works from the sample history of each channel, the
//   number of stable-delay edges per channel, and a sticky error per channel.
//   The outputs are checked on every falling edge. A few hand-computed literal
//   values pin the model itself.
//   The bench honours OUTPUT_REG_EN when that macro is defined.
module tb_multich_variable_delay;
    localparam int DW   = 16;
    localparam int CH   = 4;
    localparam int MAXD = 64;
    localparam int DWD  = $clog2(MAXD + 1);
    localparam int HD   = 4096;
`ifdef OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    multich_variable_delay_if #(.DATA_WIDTH(DW), .CH_NUM(CH), .MAX_DELAY_LENGTH(MAXD)) bus ();

    multich_variable_delay #(.DATA_WIDTH(DW), .CH_NUM(CH), .MAX_DELAY_LENGTH(MAXD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    bit          check_en   = 1'b0;
    int          post_edge  = 0;
    int          dly_req [CH];
    logic [DW-1:0] din_val [CH];

    // Reference model state.
    logic [DW-1:0] hist_m [CH][HD];
    int            edge_cnt = 0;
    int            stable_m [CH];
    int            prev_m   [CH];
    bit            err_m    [CH];
    logic [DW-1:0] reg_dout [CH];
    bit            reg_valid[CH];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        for (int c = 0; c < CH; c++) begin
            bus.DIN[c*DW +: DW]    = din_val[c];
            bus.DELAY[c*DWD +: DWD] = DWD'(dly_req[c]);
        end
    endtask

    function automatic int rawOf(int c);
        return int'(bus.DELAY[c*DWD +: DWD]);
    endfunction

    function automatic int effOf(int c);
        return (rawOf(c) > MAXD) ? MAXD : rawOf(c);
    endfunction

    // The history is complete once the delay has been stable for at least N edges.
    function automatic bit combValid(int c);
        return (RST !== 1'b1) && (stable_m[c] >= effOf(c));
    endfunction

    function automatic logic [DW-1:0] combDout(int c);
        int n;
        n = effOf(c);
        if (!combValid(c)) return '0;
        if (n == 0) return bus.DIN[c*DW +: DW];
        return hist_m[c][(edge_cnt - n) % HD];
    endfunction

    // Model update. The registered view captures the outputs as they were just
    // before this edge. The sample is recorded, and the stable-edge counts and
    // the error flags advance.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < CH; c++) begin
                stable_m[c]  = 0;
                prev_m[c]    = 0;
                err_m[c]     = 1'b0;
                reg_dout[c]  = '0;
                reg_valid[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                reg_dout[c]  = combDout(c);
                reg_valid[c] = combValid(c);
            end
            for (int c = 0; c < CH; c++) begin
                hist_m[c][edge_cnt % HD] = bus.DIN[c*DW +: DW];
                if (rawOf(c) > MAXD) err_m[c] = 1'b1;
                if (effOf(c) != prev_m[c]) stable_m[c] = 0;
                else if (stable_m[c] < MAXD) stable_m[c]++;
                prev_m[c] = effOf(c);
            end
            edge_cnt++;
        end
    end

    // Compare the DUT with the model on every falling edge.
    always @(negedge CLK) begin
        if (check_en) begin
            for (int c = 0; c < CH; c++) begin
                logic [DW-1:0] exp_d;
                bit            exp_v;
`ifdef OUTPUT_REG_EN
                exp_d = reg_dout[c];
                exp_v = reg_valid[c];
`else
                exp_d = combDout(c);
                exp_v = combValid(c);
`endif
                checkOutput($sformatf("dout[%0d]", c), 32'(bus.DOUT[c*DW +: DW]), 32'(exp_d));
                checkOutput($sformatf("valid[%0d]", c), 32'(bus.DOUT_VALID[c]), 32'(exp_v));
                checkOutput($sformatf("err[%0d]", c), 32'(bus.DELAY_ERR[c]), 32'(err_m[c]));
            end
        end
    end

    // Advance n edges. Inputs change 1 time unit after each rising edge, and
    // the task returns at a falling edge. In ramp mode the sample for channel c
    // at post-reset edge e is e+c.
    task automatic runCycles(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            post_edge++;
            #1;
            for (int c = 0; c < CH; c++) begin
                if (ramp) begin
                    din_val[c] = DW'(post_edge + 1 + c);
                end else begin
                    din_val[c] = DW'($urandom);
                    if ($urandom_range(0, 19) == 0) dly_req[c] = $urandom_range(0, 80);
                end
            end
            applyStimulus();
            @(negedge CLK);
        end
    endtask

    initial begin
        int k;
        RST = 1'b1;
        for (int c = 0; c < CH; c++) begin
            dly_req[c] = 0;
            din_val[c] = '0;
        end
        applyStimulus();
        repeat (3) @(posedge CLK);

        // Scenario 1: delays {0,1,5,64} with a ramp on every channel.
        dly_req[0] = 0; dly_req[1] = 1; dly_req[2] = 5; dly_req[3] = 64;
        for (int c = 0; c < CH; c++) din_val[c] = DW'(1 + c);
        applyStimulus();
        @(negedge CLK);
        check_en = 1'b1;
        checkOutput("valid_in_reset", 32'(bus.DOUT_VALID), 32'h0);
        #2;
        RST = 1'b0;
        post_edge = 0;
        #1;
        checkOutput("ch0_valid_at_release", 32'(bus.DOUT_VALID[0]), (LAT == 0) ? 32'h1 : 32'h0);
        runCycles(5 + LAT, 1'b1);
        checkOutput("ch2_valid_edge5", 32'(bus.DOUT_VALID[2]), 32'h0);
        runCycles(1, 1'b1);
        checkOutput("ch2_valid_edge6", 32'(bus.DOUT_VALID[2]), 32'h1);
        checkOutput("ch2_dout_edge6", 32'(bus.DOUT[2*DW +: DW]), 32'd4);
        runCycles(4, 1'b1);
        checkOutput("ch1_dout_edge10", 32'(bus.DOUT[1*DW +: DW]), 32'd11);
        checkOutput("ch0_dout_edge10", 32'(bus.DOUT[0 +: DW]), 32'd11);
        runCycles(54, 1'b1);
        checkOutput("ch3_valid_edge64", 32'(bus.DOUT_VALID[3]), 32'h0);
        runCycles(1, 1'b1);
        checkOutput("ch3_valid_edge65", 32'(bus.DOUT_VALID[3]), 32'h1);
        checkOutput("ch3_dout_edge65", 32'(bus.DOUT[3*DW +: DW]), 32'd5);

        // Scenario 2: channel 2 is held at 8, then changed to 3 at edge k.
        #2; dly_req[2] = 8; applyStimulus();
        runCycles(20, 1'b1);
        checkOutput("ch2_valid_at8", 32'(bus.DOUT_VALID[2]), 32'h1);
        #2; dly_req[2] = 3; applyStimulus();
        k = post_edge + 1;
        runCycles(1 + LAT, 1'b1);
        checkOutput("ch2_valid_k", 32'(bus.DOUT_VALID[2]), 32'h0);
        checkOutput("ch2_dout_k", 32'(bus.DOUT[2*DW +: DW]), 32'h0);
        runCycles(2, 1'b1);
        checkOutput("ch2_valid_k2", 32'(bus.DOUT_VALID[2]), 32'h0);
        runCycles(1, 1'b1);
        checkOutput("ch2_valid_k3", 32'(bus.DOUT_VALID[2]), 32'h1);
        checkOutput("ch2_dout_k3", 32'(bus.DOUT[2*DW +: DW]), 32'(k + 1 + 2));

        // Scenario 3: an out-of-range delay on channel 1 sets the sticky error.
        #2; dly_req[1] = 100; applyStimulus();
        runCycles(1, 1'b1);
        checkOutput("ch1_err_set", 32'(bus.DELAY_ERR[1]), 32'h1);
        runCycles(80, 1'b1);
        #2; dly_req[1] = 4; applyStimulus();
        runCycles(10, 1'b1);
        checkOutput("ch1_err_sticky", 32'(bus.DELAY_ERR[1]), 32'h1);

        // Scenario 4: a reset pulse in mid-stream, followed by a refill.
        #2; RST = 1'b1;
        #1;
        checkOutput("rst_valid_zero", 32'(bus.DOUT_VALID), 32'h0);
        checkOutput("rst_dout_zero", 32'(bus.DOUT[31:0]), 32'h0);
        checkOutput("rst_err_clear", 32'(bus.DELAY_ERR), 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        #2;
        dly_req[0] = 0; dly_req[1] = 1; dly_req[2] = 5; dly_req[3] = 64;
        for (int c = 0; c < CH; c++) din_val[c] = DW'(1 + c);
        applyStimulus();
        RST = 1'b0;
        post_edge = 0;
        runCycles(5 + LAT, 1'b1);
        checkOutput("refill_ch2_edge5", 32'(bus.DOUT_VALID[2]), 32'h0);
        runCycles(1, 1'b1);
        checkOutput("refill_ch2_edge6", 32'(bus.DOUT_VALID[2]), 32'h1);
        checkOutput("refill_err_clear", 32'(bus.DELAY_ERR[1]), 32'h0);

        // Scenario 5: all channels at delay 64 across several pointer wraps.
        #2;
        for (int c = 0; c < CH; c++) dly_req[c] = 64;
        applyStimulus();
        runCycles(200, 1'b1);
        checkOutput("wrap_ch3", 32'(bus.DOUT[3*DW +: DW]), 32'((post_edge - LAT) - 63 + 3));

        // Random phase: random data with occasional delay changes, some of them out of range.
        runCycles(600, 1'b0);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule
